// File: rtl/uart_cpld_responder.sv
// CPU-facing stand-in for the CPLD parallel UART: wrn writes go out 8N1 on txd, rxd frames land in RBR.
// Latency: wrn rise at N -> tbre=0 at N+1, start bit at N+2; data_ready one cycle after stop mid-bit.
// No backpressure: commits while THR is full are dropped; RBR is overwritten by the newest byte. UART_LOOPBACK_EN feeds txd to RX.
module uart_cpld_responder #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  inout  wire  [7:0] data,
  output logic       tbre,
  output logic       tsre,
  output logic       data_ready,
  output logic       txd,
  input  logic       rxd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Write path / transmitter
  logic [7:0]       thr;
  logic             wr_act_q;
  logic             wr_commit;
  state_t           tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_sh;

  // Receiver
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_in;
  logic             rx_prev;
  state_t           rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_sh;
  logic [7:0]       rbr;
  logic             rdn_q;

  assign data = rdn ? 8'hzz : rbr;

  // A write that overlapped a read strobe never arms the commit.
  assign wr_commit = wr_act_q && wrn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr      <= 8'h00;
      wr_act_q <= 1'b0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_sh    <= 8'h00;
    end else begin
      wr_act_q <= !wrn && rdn;
      if (!wrn && rdn && tbre) begin
        thr <= data;
      end
      if (wr_commit && tbre) begin
        tbre <= 1'b0;
      end

      case (tx_state)
        ST_IDLE: begin
          if (!tbre) begin
            tx_sh    <= thr;
            tbre     <= 1'b1;
            tsre     <= 1'b0;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            txd      <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_idx   <= 3'd0;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              txd    <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_idx <= tx_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            // Back-to-back frames: reload straight into a start bit, line never idles.
            if (!tbre) begin
              tx_sh    <= thr;
              tbre     <= 1'b1;
              txd      <= 1'b0;
              tx_state <= ST_START;
            end else begin
              tsre     <= 1'b1;
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_in = txd;
`else
  assign rx_in = rx_s2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev    <= 1'b1;
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= 3'd0;
      rx_sh      <= 8'h00;
      rbr        <= 8'h00;
      data_ready <= 1'b0;
      rdn_q      <= 1'b1;
    end else begin
      rx_prev <= rx_in;
      rdn_q   <= rdn;
      if (!rdn_q && rdn) begin
        data_ready <= 1'b0;
      end

      // The RBR load below is later in the block, so it beats a same-cycle read clear.
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_cnt   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rx_in) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_idx   <= 3'd0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_in, rx_sh[7:1]};
            if (rx_idx == 3'd7) begin
              rx_state <= ST_STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
            if (rx_in) begin
              rbr        <= rx_sh;
              data_ready <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
